// File: rtl/dot_field_if.sv
// Bundle of the dot_field play-side signals: frame strobe, player position,
// dot layout and level restart in; eaten map, score and status flags out.
interface dot_field_if #(
  parameter int NUM_DOTS = 32,
  parameter int COORD_W  = 10,
  parameter int SCORE_W  = 16
);
  localparam int CNT_W = $clog2(NUM_DOTS + 1);

  logic                frame_tick;
  logic [COORD_W-1:0]  pX;
  logic [COORD_W-1:0]  pY;
  logic [COORD_W-1:0]  dX [0:NUM_DOTS-1];
  logic [COORD_W-1:0]  dY [0:NUM_DOTS-1];
  logic                restart;

  logic [NUM_DOTS-1:0] eaten;
  logic [CNT_W-1:0]    dots_remaining;
  logic [SCORE_W-1:0]  score;
  logic                eat_pulse;
  logic                power_pulse;
  logic                power_active;
  logic                busy;
  logic                level_clear;

  modport master (
    output frame_tick, pX, pY, dX, dY, restart,
    input  eaten, dots_remaining, score, eat_pulse, power_pulse,
           power_active, busy, level_clear
  );

  modport slave (
    input  frame_tick, pX, pY, dX, dY, restart,
    output eaten, dots_remaining, score, eat_pulse, power_pulse,
           power_active, busy, level_clear
  );
endinterface

// File: rtl/dot_field.sv
// Dot-eating tracker: each frame scans every dot once against the latched
// player position, scoring hits, arming the power timer and flagging level clear.
module dot_field #(
  parameter int                  NUM_DOTS     = 32,
  parameter int                  COORD_W      = 10,
  parameter int                  HIT_TOL      = 0,
  parameter logic [NUM_DOTS-1:0] POWER_MASK   = '0,
  parameter int                  DOT_POINTS   = 10,
  parameter int                  POWER_POINTS = 50,
  parameter int                  POWER_TICKS  = 600,
  parameter int                  SCORE_W      = 16
) (
  input  logic Clk,
  input  logic Reset,
  dot_field_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_DOTS);
  localparam int CNT_W = $clog2(NUM_DOTS + 1);
  localparam int TMR_W = (POWER_TICKS > 0) ? $clog2(POWER_TICKS + 1) : 1;

  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_DOTS - 1);
  localparam logic [CNT_W-1:0]   FULL_CNT  = CNT_W'(NUM_DOTS);
  localparam logic [TMR_W-1:0]   TICKS_LD  = TMR_W'(POWER_TICKS);
  localparam logic [COORD_W:0]   TOL       = (COORD_W + 1)'(HIT_TOL);
  // Point values wider than the score register are clamped to full scale
  localparam logic [SCORE_W-1:0] DOT_PTS   = ((DOT_POINTS >> SCORE_W) != 0) ? '1 : SCORE_W'(DOT_POINTS);
  localparam logic [SCORE_W-1:0] PWR_PTS   = ((POWER_POINTS >> SCORE_W) != 0) ? '1 : SCORE_W'(POWER_POINTS);

  typedef enum logic [1:0] {IDLE, SCAN, CLEAR} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [COORD_W-1:0]  plx_q, plx_d;
  logic [COORD_W-1:0]  ply_q, ply_d;
  logic [NUM_DOTS-1:0] eaten_q, eaten_d;
  logic [CNT_W-1:0]    remain_q, remain_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                eat_pulse_q, eat_pulse_d;
  logic                power_pulse_q, power_pulse_d;

  logic [COORD_W:0]    diff_x, diff_y, mag_x, mag_y;
  logic [SCORE_W-1:0]  pts;
  logic                hit, is_power;

  // Differences carry one extra bit so a far-apart pair never aliases to near
  always_comb begin
    diff_x   = {1'b0, bus.dX[idx_q]} - {1'b0, plx_q};
    diff_y   = {1'b0, bus.dY[idx_q]} - {1'b0, ply_q};
    mag_x    = diff_x[COORD_W] ? (~diff_x + 1'b1) : diff_x;
    mag_y    = diff_y[COORD_W] ? (~diff_y + 1'b1) : diff_y;
    is_power = POWER_MASK[idx_q];
    pts      = is_power ? PWR_PTS : DOT_PTS;
    hit      = (state_q == SCAN) && !eaten_q[idx_q] && (mag_x <= TOL) && (mag_y <= TOL);
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    plx_d         = plx_q;
    ply_d         = ply_q;
    eaten_d       = eaten_q;
    remain_d      = remain_q;
    score_d       = score_q;
    timer_d       = timer_q;
    eat_pulse_d   = 1'b0;
    power_pulse_d = 1'b0;

    if (bus.frame_tick && (timer_q != '0)) begin
      timer_d = timer_q - 1'b1;
    end

    if (bus.restart) begin
      state_d  = IDLE;
      idx_d    = '0;
      eaten_d  = '0;
      remain_d = FULL_CNT;
      timer_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.frame_tick) begin
            plx_d   = bus.pX;
            ply_d   = bus.pY;
            idx_d   = '0;
            state_d = SCAN;
          end
        end
        SCAN: begin
          if (hit) begin
            eaten_d[idx_q] = 1'b1;
            remain_d       = remain_q - 1'b1;
            score_d        = (pts > ~score_q) ? '1 : score_q + pts;
            eat_pulse_d    = 1'b1;
            if (is_power) begin
              power_pulse_d = 1'b1;
              timer_d       = TICKS_LD;
            end
          end
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = (remain_d == '0) ? CLEAR : IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        CLEAR: begin
          state_d = CLEAR;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      plx_q         <= '0;
      ply_q         <= '0;
      eaten_q       <= '0;
      remain_q      <= FULL_CNT;
      score_q       <= '0;
      timer_q       <= '0;
      eat_pulse_q   <= 1'b0;
      power_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      plx_q         <= plx_d;
      ply_q         <= ply_d;
      eaten_q       <= eaten_d;
      remain_q      <= remain_d;
      score_q       <= score_d;
      timer_q       <= timer_d;
      eat_pulse_q   <= eat_pulse_d;
      power_pulse_q <= power_pulse_d;
    end
  end

  assign bus.eaten          = eaten_q;
  assign bus.dots_remaining = remain_q;
  assign bus.score          = score_q;
  assign bus.eat_pulse      = eat_pulse_q;
  assign bus.power_pulse    = power_pulse_q;
  assign bus.power_active   = (timer_q != '0);
  assign bus.busy           = (state_q == SCAN);
  assign bus.level_clear    = (state_q == CLEAR);

endmodule
